// File: rtl/seq_mul_nxm.sv
// Radix-2 shift-add N x M multiplier with a start/done handshake.
// Signed operands run as magnitudes, and the sign is applied in FIN.
module seq_mul_nxm #(
  parameter int unsigned N = 8,
  parameter int unsigned M = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [N-1:0]     a,
  input  logic [M-1:0]     b,
  output logic             busy,
  output logic             done,
  output logic [N+M-1:0]   p
);

  localparam int unsigned W  = N + M;
  localparam int unsigned CW = $clog2(M);

  typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

  state_t          state_q, state_d;
  logic [N-1:0]    mcand_q, mcand_d;
  logic [M-1:0]    mplier_q, mplier_d;
  logic            neg_q, neg_d;
  logic [W-1:0]    acc_q, acc_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [W-1:0]    p_q, p_d;
  logic [N-1:0]    a_mag;
  logic [M-1:0]    b_mag;

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      neg_q    <= 1'b0;
      acc_q    <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      p_q      <= '0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      neg_q    <= neg_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      p_q      <= p_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = CALC;
      CALC:    if (cnt_q == CW'(M - 1)) state_d = FIN;
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath and output next values
  always_comb begin
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    neg_d    = neg_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    p_d      = p_q;
    done_d   = 1'b0;
    busy_d   = (state_d != IDLE);
    a_mag    = a[N-1] ? ((~a) + N'(1)) : a;
    b_mag    = b[M-1] ? ((~b) + M'(1)) : b;
    case (state_q)
      IDLE: begin
        if (start) begin
          mcand_d  = signed_mode ? a_mag : a;
          mplier_d = signed_mode ? b_mag : b;
          neg_d    = signed_mode & (a[N-1] ^ b[M-1]);
          acc_d    = '0;
          cnt_d    = '0;
        end
      end
      CALC: begin
        if (mplier_q[0]) acc_d = acc_q + (W'(mcand_q) << cnt_q);
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CW'(1);
      end
      FIN: begin
        p_d    = neg_q ? ((~acc_q) + W'(1)) : acc_q;
        done_d = 1'b1;
      end
      default: ;
    endcase
  end

  assign busy = busy_q;
  assign done = done_q;
  assign p    = p_q;

endmodule

// File: tb/tb_seq_mul_nxm.sv
// Self-checking bench for seq_mul_nxm: 8x8, 4x12 and 12x4 instances, scoreboard of products.
module tb_seq_mul_nxm;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        start0, sm0, busy0, done0;
  logic [7:0]  a0, b0;
  logic [15:0] p0;
  logic        start1, sm1, busy1, done1;
  logic [3:0]  a1;
  logic [11:0] b1;
  logic [15:0] p1;
  logic        start2, sm2, busy2, done2;
  logic [11:0] a2;
  logic [3:0]  b2;
  logic [15:0] p2;

  seq_mul_nxm #(.N(8), .M(8)) u_m8x8 (
    .clk(clk), .rst(rst), .start(start0), .signed_mode(sm0), .a(a0), .b(b0),
    .busy(busy0), .done(done0), .p(p0));
  seq_mul_nxm #(.N(4), .M(12)) u_m4x12 (
    .clk(clk), .rst(rst), .start(start1), .signed_mode(sm1), .a(a1), .b(b1),
    .busy(busy1), .done(done1), .p(p1));
  seq_mul_nxm #(.N(12), .M(4)) u_m12x4 (
    .clk(clk), .rst(rst), .start(start2), .signed_mode(sm2), .a(a2), .b(b2),
    .busy(busy2), .done(done2), .p(p2));

  int n_checks = 0;
  int n_fail   = 0;
  logic [15:0] sb[$];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input int cfg, input logic st, input logic sm,
                        input logic [11:0] av, input logic [11:0] bv);
    case (cfg)
      0: begin start0 = st; sm0 = sm; a0 = av[7:0]; b0 = bv[7:0]; end
      1: begin start1 = st; sm1 = sm; a1 = av[3:0]; b1 = bv;      end
      default: begin start2 = st; sm2 = sm; a2 = av; b2 = bv[3:0]; end
    endcase
  endtask

  function automatic logic done_of(input int cfg);
    return (cfg == 0) ? done0 : (cfg == 1) ? done1 : done2;
  endfunction

  function automatic logic busy_of(input int cfg);
    return (cfg == 0) ? busy0 : (cfg == 1) ? busy1 : busy2;
  endfunction

  function automatic logic [15:0] p_of(input int cfg);
    return (cfg == 0) ? p0 : (cfg == 1) ? p1 : p2;
  endfunction

  function automatic int m_of(input int cfg);
    return (cfg == 0) ? 8 : (cfg == 1) ? 12 : 4;
  endfunction

  // Reference product from integer arithmetic, truncated to the 16-bit product
  function automatic logic [15:0] ref_mul(input int cfg, input logic [11:0] av,
                                          input logic [11:0] bv, input logic sm);
    int na, nb;
    longint x, y;
    na = 16 - m_of(cfg);
    nb = m_of(cfg);
    x = longint'(av) % (longint'(1) << na);
    y = longint'(bv) % (longint'(1) << nb);
    if (sm && x >= (longint'(1) << (na - 1))) x = x - (longint'(1) << na);
    if (sm && y >= (longint'(1) << (nb - 1))) y = y - (longint'(1) << nb);
    return 16'(x * y);
  endfunction

  task automatic run_op(input int cfg, input logic [11:0] av, input logic [11:0] bv,
                        input logic sm, input logic [15:0] exp_p, input string name);
    int lat, bcnt;
    logic [15:0] want;
    sb.push_back(exp_p);
    set_in(cfg, 1'b1, sm, av, bv);
    tick;
    set_in(cfg, 1'b0, 1'($urandom), 12'($urandom), 12'($urandom));
    lat  = 0;
    bcnt = busy_of(cfg) ? 1 : 0;
    while (!done_of(cfg) && lat < 40) begin
      tick;
      lat++;
      if (busy_of(cfg)) bcnt++;
    end
    want = sb.pop_front();
    n_checks++;
    if (lat !== m_of(cfg) + 1) begin
      n_fail++;
      $display("FAIL %s latency: got %0d want %0d", name, lat, m_of(cfg) + 1);
    end
    n_checks++;
    if (p_of(cfg) !== want) begin
      n_fail++;
      $display("FAIL %s product: got %h want %h", name, p_of(cfg), want);
    end
    n_checks++;
    if (bcnt !== m_of(cfg) + 1) begin
      n_fail++;
      $display("FAIL %s busy_cycles: got %0d want %0d", name, bcnt, m_of(cfg) + 1);
    end
    tick;
    n_checks++;
    if (done_of(cfg) !== 1'b0 || p_of(cfg) !== want) begin
      n_fail++;
      $display("FAIL %s after_done: done %b p %h want done 0 p %h", name,
               done_of(cfg), p_of(cfg), want);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    for (int c = 0; c < 3; c++) set_in(c, 1'b0, 1'b0, 12'd0, 12'd0);
    tick;
    tick;
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      n_checks++;
      if (busy_of(c) !== 1'b0 || done_of(c) !== 1'b0 || p_of(c) !== 16'h0) begin
        n_fail++;
        $display("FAIL reset cfg%0d: busy %b done %b p %h want 0 0 0000", c,
                 busy_of(c), done_of(c), p_of(c));
      end
    end
  endtask

  task automatic test_reset_mid;
    int seen;
    set_in(0, 1'b1, 1'b0, 12'd200, 12'd100);
    tick;
    set_in(0, 1'b0, 1'b0, 12'd0, 12'd0);
    repeat (3) tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    n_checks++;
    if (busy0 !== 1'b0 || p0 !== 16'h0) begin
      n_fail++;
      $display("FAIL reset_mid: busy %b p %h want 0 0000", busy0, p0);
    end
    seen = 0;
    repeat (12) begin
      tick;
      if (done0) seen++;
    end
    n_checks++;
    if (seen !== 0 || p0 !== 16'h0) begin
      n_fail++;
      $display("FAIL reset_mid_abort: done pulses %0d p %h want 0 0000", seen, p0);
    end
    run_op(0, 12'd3, 12'd5, 1'b0, 16'd15, "post_reset_3x5");
  endtask

  task automatic test_unsigned_full;
    run_op(0, 12'd255, 12'd255, 1'b0, 16'hFE01, "unsigned_255x255");
  endtask

  task automatic test_signed_corners;
    run_op(0, 12'h080, 12'h080, 1'b1, 16'h4000, "signed_m128xm128");
    run_op(0, 12'h080, 12'h07F, 1'b1, 16'hC080, "signed_m128x127");
    run_op(0, 12'h0FF, 12'h001, 1'b1, 16'hFFFF, "signed_m1x1");
    run_op(0, 12'h000, 12'h0FB, 1'b1, 16'h0000, "signed_0xm5");
  endtask

  task automatic test_ignore_start;
    int lat, seen;
    sb.push_back(16'd200);
    set_in(0, 1'b1, 1'b0, 12'd10, 12'd20);
    tick;
    set_in(0, 1'b0, 1'b0, 12'd0, 12'd0);
    repeat (3) tick;
    set_in(0, 1'b1, 1'b1, 12'd99, 12'd77);
    tick;
    set_in(0, 1'b0, 1'b0, 12'd0, 12'd0);
    lat = 4;
    while (!done0 && lat < 40) begin
      tick;
      lat++;
    end
    n_checks++;
    if (lat !== 9 || p0 !== sb[0]) begin
      n_fail++;
      $display("FAIL ignore_start: lat %0d p %h want 9 %h", lat, p0, sb[0]);
    end
    void'(sb.pop_front());
    seen = 0;
    repeat (12) begin
      tick;
      if (done0) seen++;
    end
    n_checks++;
    if (seen !== 0) begin
      n_fail++;
      $display("FAIL ignore_start_queued: extra done pulses %0d want 0", seen);
    end
  endtask

  task automatic test_back_to_back;
    int lat, gap;
    sb.push_back(16'd143);
    set_in(0, 1'b1, 1'b0, 12'd13, 12'd11);
    tick;
    set_in(0, 1'b0, 1'b0, 12'd0, 12'd0);
    lat = 0;
    while (!done0 && lat < 40) begin
      tick;
      lat++;
    end
    n_checks++;
    if (p0 !== sb[0] || lat !== 9) begin
      n_fail++;
      $display("FAIL b2b_first: p %h lat %0d want %h 9", p0, lat, sb[0]);
    end
    void'(sb.pop_front());
    sb.push_back(16'hFFD6);
    set_in(0, 1'b1, 1'b1, 12'h0FA, 12'h007);
    tick;
    set_in(0, 1'b0, 1'b0, 12'd0, 12'd0);
    gap = 1;
    while (!done0 && gap < 40) begin
      tick;
      gap++;
    end
    n_checks++;
    if (gap !== 10 || p0 !== sb[0]) begin
      n_fail++;
      $display("FAIL b2b_second: gap %0d p %h want 10 %h", gap, p0, sb[0]);
    end
    void'(sb.pop_front());
    tick;
  endtask

  task automatic test_param_sweep;
    run_op(1, 12'h007, 12'h800, 1'b1, 16'hC800, "n4m12_7xm2048");
    run_op(2, 12'hFFF, 12'h00F, 1'b0, 16'd61425, "n12m4_4095x15");
  endtask

  task automatic test_random;
    logic [11:0] av, bv;
    logic sm;
    for (int c = 0; c < 3; c++) begin
      for (int i = 0; i < 1000; i++) begin
        av = 12'($urandom);
        bv = 12'($urandom);
        sm = 1'($urandom);
        run_op(c, av, bv, sm, ref_mul(c, av, bv, sm), $sformatf("random_cfg%0d_%0d", c, i));
      end
    end
  endtask

  initial begin
    test_reset;
    test_reset_mid;
    test_unsigned_full;
    test_signed_corners;
    test_ignore_start;
    test_back_to_back;
    test_param_sweep;
    test_random;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_mul_nxm.md
# seq_mul_nxm

Parametrised sequential N×M multiplier. It replaces fixed-width combinational multiply with a radix-2 shift-add datapath and a start/done handshake, and it supports both unsigned and two's-complement signed operands. It sits beside the arithmetic modules in Modules/ and is used wherever a small-area, fixed-latency multiply is acceptable. Latency is fixed at M+1 cycles regardless of operand values.

## Interface
Parameters:
- N, default 8: multiplicand width (a); must be ≥ 2.
- M, default 8: multiplier width (b); must be ≥ 2; sets iteration count.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- signed_mode  input  1  1 = a and b are two's complement; 0 = unsigned. Sampled with start.
- a  input  N  multiplicand, sampled with start.
- b  input  M  multiplier, sampled with start.
- busy  output  1  high while an operation is in progress.
- done  output  1  single-cycle pulse when p is updated.
- p  output  N+M  product; holds the last result until the next done.

## Operation
- FSM states:
  - IDLE: busy=0. If start=1, latch operands and go to CALC.
  - CALC: busy=1. Runs exactly M iterations, then goes to FIN.
  - FIN: busy=1. Writes p, pulses done, returns to IDLE.
- Operand latch (IDLE, start=1):
  - signed_mode=1:
    - mcand ← |a| (N-bit unsigned).
    - mplier ← |b| (M-bit unsigned).
    - neg ← a[N-1] ^ b[M-1].
  - signed_mode=0: mcand ← a, mplier ← b, neg ← 0.
  - acc (N+M bits) ← 0; cnt ← 0.
- Magnitude of the most negative value (e.g. −2^(N-1)) is 2^(N-1), which fits N unsigned bits. No overflow is possible.
- CALC iteration i (cnt=i, 0..M-1):
  - If mplier[0]=1: acc ← acc + (mcand << i), zero-extended to N+M bits.
  - mplier ← mplier >> 1; cnt ← cnt+1.
  - After the iteration with cnt=M-1, go to FIN.
- FIN:
  - p ← neg ? (~acc + 1) : acc, all N+M bits.
  - done ← 1 for this edge only; busy ← 0; state ← IDLE.
- No early termination: zero or small operands still take M iterations.
- start while busy=1 is ignored and not queued. Inputs a, b and signed_mode may change freely after the sampling edge.
- Product width N+M holds every full-range result. Unsigned: (2^N−1)(2^M−1). Signed: (−2^(N-1))(−2^(M-1)) = 2^(N+M-2).

## Timing
- Reset (rst=1 at an edge) has priority over all other activity and applies from any state, including mid-CALC. Resulting state:
  - state=IDLE.
  - busy=0, done=0, p=0.
  - acc, cnt, mplier, mcand, neg all cleared.
- An aborted operation produces no done and p stays 0.
- Start sampled at edge k:
  - busy=1 from after edge k.
  - CALC occupies edges k+1..k+M.
  - FIN occupies edge k+M+1: p valid, done=1, busy=0.
  - Latency is M+1 cycles from start to done.
- done is high for exactly one cycle, after edge k+M+1, and is low at all other times.
- Back-to-back: start=1 in the cycle where done=1 is accepted at the next edge, because state is already IDLE. Maximum throughput is one result per M+2 cycles.
- start held continuously high restarts the multiplier each time it returns to IDLE, using the current a and b.
- p changes only at a FIN edge or at reset.

## Test plan
- Reset mid-operation:
  - Stimulus (N=M=8): start with a=200, b=100; assert rst at the 4th CALC edge; release rst.
  - Response: busy=0, p=0, no done pulse. A following start with a=3, b=5 gives p=15 with done exactly 9 cycles after the start edge.
- Unsigned full range:
  - Stimulus: signed_mode=0, a=255, b=255.
  - Response: p=65025 (0xFE01). done at edge k+9. busy high for exactly 9 cycles.
- Signed corners:
  - (−128)×(−128) → p=16384 (0x4000).
  - (−128)×127 → p=−16256 (0xC080).
  - (−1)×1 → p=0xFFFF.
  - 0×(−5) → p=0, with no negative zero.
- Handshake:
  - Pulse start again during CALC with different operands: ignored, and the first result is unchanged.
  - start=1 during the done cycle: second result arrives M+2 cycles after the first done.
- Parameter sweep:
  - N=4, M=12, signed: 7×(−2048) → p=−14336 (16-bit 0xC800), done at k+13.
  - N=12, M=4, unsigned: 4095×15 → p=61425.
  - Random compare against a reference product, ≥1000 vectors per configuration.
